// File: rtl/gigatron_uart_scheduler.sv
// gigatron_uart_scheduler
// Shares one UART transmitter between the vsync-decoded byte stream (buffered
// in a small FIFO) and a debug/host requester. Grants alternate round-robin
// when both sources are pending. The UART start/busy handshake is sequenced
// by a three-state FSM, and a busy acknowledge that never arrives times out.
module gigatron_uart_scheduler #(
  parameter int FIFO_AW = 4,   // FIFO address width, depth = 2**FIFO_AW
  parameter int TIMEOUT = 15   // WAIT_BUSY cycles before giving up, 1..15
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [7:0]         dec_data,
  input  logic               dec_ready,
  input  logic               dbg_req,
  input  logic [7:0]         dbg_data,
  output logic               dbg_ack,
  input  logic               uart_busy,
  output logic [7:0]         uart_data,
  output logic               uart_start,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int                DEPTH       = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_COUNT  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [3:0]        TIMEOUT_CNT = TIMEOUT[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  typedef enum logic {
    GRANT_FIFO,
    GRANT_DBG
  } grant_t;

  // FIFO storage and pointers
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  // Decoder edge detect
  logic dec_ready_d;
  logic push;
  logic push_ok;

  // Scheduler state
  state_t     state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic [3:0] timer_q, timer_d;
  logic       grant;
  logic       grant_dbg;
  logic       pop;
  logic       fifo_pending;

  // A new byte is one rising edge of the decoder's valid level.
  assign push         = dec_ready & ~dec_ready_d;
  assign fifo_pending = (fifo_count != '0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok      = push & ((fifo_count != FULL_COUNT) | pop);

  // Next-state, arbitration and timeout decisions for the UART handshake.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    grant        = 1'b0;
    grant_dbg    = 1'b0;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!uart_busy && (fifo_pending || dbg_req)) begin
          grant = 1'b1;
          // Debug wins when it is alone, or when both wait and FIFO went last.
          grant_dbg    = dbg_req && (!fifo_pending || (last_grant_q == GRANT_FIFO));
          pop          = !grant_dbg;
          last_grant_d = grant_dbg ? GRANT_DBG : GRANT_FIFO;
          timer_d      = '0;
          state_d      = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (uart_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          timer_d = timer_q + 4'd1;
          // The byte is considered sent; it is never retried.
          if (timer_d == TIMEOUT_CNT) state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, arbitration history and timeout counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_DBG;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
    end
  end

  // FIFO storage write.
  // NOTE: the byte array has no reset; resetting the pointers and count
  // already makes old contents unreachable, and a reset-free array maps to RAM.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem[wr_ptr] <= dec_data;
  end

  // FIFO pointers, occupancy, edge-detect history and sticky overflow.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      overflow    <= 1'b0;
      // Starting high keeps a level already present at reset release silent.
      dec_ready_d <= 1'b1;
    end else begin
      dec_ready_d <= dec_ready;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // Registered UART/debug outputs; uart_data only moves on a grant.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      uart_data  <= '0;
      uart_start <= 1'b0;
      dbg_ack    <= 1'b0;
    end else begin
      uart_start <= grant;
      dbg_ack    <= grant & grant_dbg;
      if (grant) uart_data <= grant_dbg ? dbg_data : mem[rd_ptr];
    end
  end

endmodule
